// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a two-flop input synchroniser feeding a
// first-word-fall-through FIFO read via a valid/ready handshake.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_in,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     frame_err,
  output logic                     overrun,
  input  logic                     clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_M1 = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;

  logic            rx_s;
  logic            push;
  logic            fe_set;
  logic            pop;
  logic            full;
  logic            push_ok;
  logic            ovr_set;

  assign sync_d = {sync_q[0], rx_in};
  assign rx_s   = sync_q[1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and receive datapath
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          state_d = rx_s ? S_IDLE : S_BREAK;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_BREAK: begin
        baud_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // FSM outputs: stop-bit verdict
  always_comb begin
    push   = 1'b0;
    fe_set = 1'b0;
    if (state_q == S_STOP && baud_q == FULL_M1) begin
      push   = rx_s;
      fe_set = !rx_s;
    end
  end

  // A full FIFO still takes a push when the head is popped in the same cycle
  always_comb begin
    pop      = rd_valid & rd_ready;
    full     = (count_q == DEPTH_C);
    push_ok  = push & (~full | pop);
    ovr_set  = push & ~push_ok;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    frame_err_d = (frame_err_q & ~clr_err) | fe_set;
    overrun_d   = (overrun_q & ~clr_err) | ovr_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '1;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sync_q      <= sync_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data    = mem_q[rd_ptr_q];
  assign rd_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receive front-end for the PC serial link on the FPGA board. It sits on the `uart_rx` pin path, upstream of the SoC, and tapped in parallel with the SoC's own UART input. It synchronises and deserialises 8N1 frames and buffers the received bytes in a first-word-fall-through FIFO. Fabric-side consumers (boot loader, debug bridge) read the bytes through a valid/ready handshake.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200, floored); must be ≥ 8.
- `DEPTH`, default 16: FIFO entries; power of two, ≥ 2.
- `clk`  in  1: the single clock domain of the block.
- `rst`  in  1: reset; asynchronous, active-high.
- `rx_in`  in  1: raw serial line from the PC; asynchronous to `clk`; idle high.
- `rd_data`  out  8: byte at the FIFO head.
- `rd_valid`  out  1: FIFO not empty.
- `rd_ready`  in  1: consumer accepts `rd_data` when `rd_valid & rd_ready`.
- `fifo_count`  out  $clog2(DEPTH)+1: occupancy.
- `frame_err`  out  1: sticky; a stop bit was sampled low.
- `overrun`  out  1: sticky; a good byte arrived while the FIFO was full.
- `clr_err`  in  1: one-cycle pulse that clears both sticky flags.

## Operation
- Reset values:
  - Synchroniser flops reset to 1, so no false start bit is seen out of reset.
  - FSM goes to IDLE; bit and baud counters go to 0.
  - FIFO pointers and `fifo_count` go to 0, so `rd_valid` is 0.
  - `frame_err` and `overrun` go to 0; `rd_data` resets to 0x00.
- `rx_in` passes through a 2-flop synchroniser to produce `rx_s`. All logic below uses `rx_s`.
- FSM states:
  - IDLE: on `rx_s`=0, go to START and clear the baud counter.
  - START: at baud count `CLKS_PER_BIT/2 - 1`:
    - if `rx_s`=0, go to DATA with the counter cleared and bit index 0;
    - otherwise go to IDLE (glitch rejected).
  - DATA: each time the baud count reaches `CLKS_PER_BIT-1`:
    - sample `rx_s` into the shift register, LSB first, and clear the counter;
    - after bit 7, go to STOP.
  - STOP: at baud count `CLKS_PER_BIT-1`, sample `rx_s`:
    - if 1: push the byte and go to IDLE;
    - if 0: set `frame_err`, drop the byte, and go to BREAK.
  - BREAK: stay until `rx_s`=1, then go to IDLE. A held-low line yields one `frame_err` only.
- FIFO behaviour:
  - A push is accepted when `fifo_count < DEPTH`, or when the FIFO is full and a pop happens in the same cycle.
  - A push rejected when full sets `overrun`; FIFO contents are unchanged.
  - Pop occurs on `rd_valid & rd_ready`. `rd_ready` while empty has no effect.
  - Simultaneous push and pop leave `fifo_count` unchanged.
  - Pointers wrap modulo `DEPTH`.
- Sticky flags: if `clr_err` and a new error event occur in the same cycle, the flag ends set.
- Reset asserted mid-frame aborts the frame: the partial byte is discarded and the FIFO is emptied.

## Timing
- Let t0 be the first cycle in which `rx_s`=0 in IDLE. With H = `CLKS_PER_BIT/2`:
  - start-bit check at t0+H;
  - data bit i sampled at t0+H+(i+1)·`CLKS_PER_BIT`;
  - stop bit sampled at t0+H+9·`CLKS_PER_BIT`.
- Default values: H = 52, bit 0 at t0+156, stop bit at t0+988.
- `rx_s` lags `rx_in` by 2 cycles.
- Data bytes: `rd_valid` and `rd_data` are valid in the cycle after the stop-bit sample cycle.
- Error flags: `frame_err` and `overrun` assert in the cycle after the offending sample.
- Back-to-back frames are supported: IDLE accepts a new start bit in the cycle after STOP.
- Pop: the next entry appears on `rd_data` in the cycle after the pop, combinationally from the FIFO memory head.
- Throughput: one byte per `rd_ready` cycle.

## Test plan
- Send 0xA5 (8N1, 104 cycles per bit) → one cycle after the stop sample: `rd_valid`=1, `rd_data`=0xA5, `fifo_count`=1. Then assert `rd_ready` for 1 cycle → `rd_valid`=0, `fifo_count`=0.
- Drive `rx_in` low for 20 cycles, then high → no push, `fifo_count`=0, `frame_err`=0.
- Send 0x3C with the stop bit driven low, then hold the line low 2000 cycles → `frame_err`=1 once, no push. After the line goes high, send 0x3C correctly → received. Pulse `clr_err` → `frame_err`=0.
- Send 17 bytes 0x00..0x10 with `rd_ready`=0 → `fifo_count`=16, `overrun`=1. Drain: bytes read are 0x00..0x0F in order.
- With the FIFO full, send one byte while `rd_ready`=1 in the push cycle → push accepted, `fifo_count` stays 16, `overrun` stays 0.
- Assert `rst` during bit 4 of a frame (FIFO holding 3 bytes) → all outputs at reset values. A following clean byte 0x5A is received correctly.
